// File: rtl/riscv_core_mul_pkg.sv
// riscv_core_mul_pkg: shared multiplier op encodings and fast-path flag indices
package riscv_core_mul_pkg;
  typedef enum logic [1:0] {
    CTL_MUL    = 2'b00,
    CTL_MULH   = 2'b01,
    CTL_MULHSU = 2'b10,
    CTL_MULHU  = 2'b11
  } ctl_e;
  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_MULW
  } op_e;
  localparam int FAST_A_ONE  = 0;
  localparam int FAST_A_ZERO = 1;
  localparam int FAST_A_NEG  = 2;
  localparam int FAST_B_ONE  = 3;
  localparam int FAST_B_ZERO = 4;
  localparam int FAST_B_NEG  = 5;
endpackage

// File: rtl/riscv_core_mul_out_neg.sv
// riscv_core_mul_out_neg: conditional two's-complement negate with carry-in and zero-detect carry-out
module riscv_core_mul_out_neg #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic            neg,
  input  logic            cin,
  output logic [XLEN-1:0] y,
  output logic            cout
);
  assign y    = neg ? ~a + {{(XLEN-1){1'b0}}, cin} : a;
  assign cout = neg && (a == '0);
endmodule

// File: rtl/riscv_core_mul_out.sv
// riscv_core_mul_out: two-stage multiplier result sign-fix, select and fast-path pipeline
module riscv_core_mul_out
  import riscv_core_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mul_out_valid,
  output logic              o_mul_out_ready,
  input  logic [2*XLEN-1:0] i_mul_out_product,
  input  logic              i_mul_out_negate,
  input  logic [1:0]        i_mul_out_control,
  input  logic              i_mul_out_isword,
  input  logic [5:0]        i_mul_out_fast,
  input  logic [XLEN-1:0]   i_mul_out_srcA,
  input  logic [XLEN-1:0]   i_mul_out_srcB,
  input  logic              i_mul_out_flush,
  output logic              o_mul_out_valid,
  input  logic              i_mul_out_ready,
  output logic [XLEN-1:0]   o_mul_out_result
);
  localparam int H = XLEN / 2;

  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] v);
    return {{H{v[H-1]}}, v[H-1:0]};
  endfunction

  logic            s1_valid, s2_valid, s2_adv, acc;
  logic [XLEN-1:0] s1_lo, s1_phi, s1_fres;
  logic            s1_carry, s1_neg, s1_isw, s1_fast;
  ctl_e            s1_ctl;
  logic [XLEN-1:0] lo_n, hi_n, fres, fother, res_n;
  logic            carry_n, fhit, fzero, fone;
  logic            unused_cout, unused_fast;

  assign s2_adv          = !s2_valid || i_mul_out_ready;
  assign o_mul_out_ready = !s1_valid || s2_adv;
  assign acc             = i_mul_out_valid && o_mul_out_ready;
  assign o_mul_out_valid = s2_valid;
  assign unused_fast     = &{i_mul_out_fast[FAST_A_NEG], i_mul_out_fast[FAST_B_NEG]};

  riscv_core_mul_out_neg #(.XLEN(XLEN)) u_neg_lo (
    .a(i_mul_out_product[XLEN-1:0]), .neg(i_mul_out_negate), .cin(1'b1),
    .y(lo_n), .cout(carry_n)
  );

  riscv_core_mul_out_neg #(.XLEN(XLEN)) u_neg_hi (
    .a(s1_phi), .neg(s1_neg), .cin(s1_carry),
    .y(hi_n), .cout(unused_cout)
  );

  // fast-path detection on the incoming operands; a multiply by one forwards the other operand
  always_comb begin
    fzero  = i_mul_out_fast[FAST_A_ZERO] || i_mul_out_fast[FAST_B_ZERO];
    fone   = i_mul_out_fast[FAST_A_ONE] || i_mul_out_fast[FAST_B_ONE];
    fother = i_mul_out_fast[FAST_A_ONE] ? i_mul_out_srcB : i_mul_out_srcA;
    fhit   = fzero || (fone && (i_mul_out_isword || ctl_e'(i_mul_out_control) == CTL_MUL));
    fres   = fzero ? '0 : i_mul_out_isword ? sext(fother) : fother;
  end

  // final result selection feeding the output register
  always_comb begin
    res_n = s1_fast ? s1_fres : s1_isw ? sext(s1_lo) : s1_ctl == CTL_MUL ? s1_lo : hi_n;
  end

  // stage 1: low-half negate, raw high half and fast-path capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_phi   <= '0;
      s1_fres  <= '0;
      s1_carry <= 1'b0;
      s1_neg   <= 1'b0;
      s1_isw   <= 1'b0;
      s1_fast  <= 1'b0;
      s1_ctl   <= CTL_MUL;
    end else begin
      if (i_mul_out_flush) s1_valid <= 1'b0;
      else if (o_mul_out_ready) s1_valid <= i_mul_out_valid;
      if (acc) begin
        s1_lo    <= lo_n;
        s1_phi   <= i_mul_out_product[2*XLEN-1:XLEN];
        s1_fres  <= fres;
        s1_carry <= carry_n;
        s1_neg   <= i_mul_out_negate;
        s1_isw   <= i_mul_out_isword;
        s1_fast  <= fhit;
        s1_ctl   <= ctl_e'(i_mul_out_control);
      end
    end
  end

  // stage 2: high-half negate and selected result, held while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid         <= 1'b0;
      o_mul_out_result <= '0;
    end else begin
      if (i_mul_out_flush) s2_valid <= 1'b0;
      else if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) o_mul_out_result <= res_n;
    end
  end
endmodule
